ahb_apb4_bridge: RTL and testbench
==================================

# ahb_apb4_bridge

Parametrised AHB-Lite to APB4 bridge that converts one AHB transfer at a time into an APB4 SETUP/ACCESS sequence to one of `NUM_SLAVES` peripherals. It sits between the AHB interconnect and the APB peripheral cluster. Beyond a basic bridge, it adds configurable address/data widths, one-hot slave decode, APB wait states (`pready`), byte strobes (`pstrb`), and two-cycle AHB ERROR responses for slave errors, decode errors and access timeouts.

## Interface
- `ADDR_WIDTH`, default 32: AHB/APB address width.
- `DATA_WIDTH`, default 32: data width; allowed values are 32 or 64.
- `NUM_SLAVES`, default 4: number of APB slaves, 1..16.
- `SEL_LSB`, default 12: lowest `haddr` bit of the slave index field. The field is `SW = max(1, clog2(NUM_SLAVES))` bits wide.
- `TIMEOUT`, default 255: maximum number of ACCESS cycles waiting for `pready`, 1..65535.

Ports, one per line (name, direction, width, meaning):
- `hclk`, in, 1: the single clock.
- `hresetn`, in, 1: asynchronous, active-low reset.
- `hsel`, in, 1: bridge selected.
- `haddr`, in, ADDR_WIDTH: AHB address.
- `htrans`, in, 2: transfer type.
- `hwrite`, in, 1: write when 1.
- `hsize`, in, 3: transfer size.
- `hwdata`, in, DATA_WIDTH: write data.
- `hready_in`, in, 1: bus HREADY.
- `hrdata`, out, DATA_WIDTH: registered read data.
- `hreadyout`, out, 1: bridge ready.
- `hresp`, out, 2: `2'b00` means OKAY, `2'b01` means ERROR.
- `psel`, out, NUM_SLAVES: one-hot slave select.
- `penable`, out, 1: APB enable.
- `pwrite`, out, 1: APB write.
- `paddr`, out, ADDR_WIDTH: APB address.
- `pwdata`, out, DATA_WIDTH: APB write data.
- `pstrb`, out, DATA_WIDTH/8: APB write strobes.
- `prdata`, in, NUM_SLAVES*DATA_WIDTH: concatenated read data; slave i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `pready`, in, NUM_SLAVES: per-slave ready.
- `pslverr`, in, NUM_SLAVES: per-slave error.

## Operation
- **Accept rule.** A transfer is accepted when `hsel & hready_in & htrans[1]` holds on a clock edge, i.e. NONSEQ or SEQ. IDLE and BUSY transfers are ignored and get OKAY with zero wait. On acceptance the bridge registers `haddr`, `hwrite` and `hsize`, and sets the slave index `idx = haddr[SEL_LSB +: SW]`.
- **Decode error.** Raised when `idx >= NUM_SLAVES`, or `hsize > clog2(DATA_WIDTH/8)`, or the address is misaligned to `hsize`. A decode error goes straight to ERR1 and makes no APB access.
- **States.**
  - IDLE: `hreadyout=1`, `hresp=00`, `psel=0`.
  - WDATA: write only; `hreadyout=0`; `pwdata <= hwdata` is loaded at the end of the cycle.
  - SETUP: `psel[idx]=1`, `penable=0`.
  - ACCESS: `psel[idx]=1`, `penable=1`.
  - ERR1: `hreadyout=0`, `hresp=01`.
  - ERR2: `hreadyout=1`, `hresp=01`.
- **Transitions.**
  - IDLE → WDATA on an accepted write; IDLE → SETUP on an accepted read; IDLE → ERR1 on an accepted transfer with a decode error.
  - WDATA → SETUP unconditionally.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE when `pready[idx] & !pslverr[idx]`. On a read, `hrdata` is registered from the selected slice of `prdata` at that point.
  - ACCESS → ERR1 when `pready[idx] & pslverr[idx]`, or when the timeout counter reaches TIMEOUT.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → IDLE, or directly to WDATA/SETUP/ERR1 if a transfer is accepted in ERR2.
- **Strobes.** `pstrb = ((1 << (1 << hsize)) - 1) << (haddr mod (DATA_WIDTH/8))` for writes, and all zeros for reads (APB4 rule).
- **Output stability.** `paddr`, `pwrite`, `pwdata` and `pstrb` are registered and held constant from SETUP through the end of ACCESS.
- **Timeout counter.** Clears on entering ACCESS and increments each ACCESS cycle while `pready[idx]=0`. On timeout, `psel` and `penable` drop in the next cycle and the AHB transfer gets ERROR. A late `pready` after a timeout is ignored.
- **Unselected slaves.** `pready` and `pslverr` of slaves other than `idx` are ignored.

## Timing
- **Reset (async assert, synchronous-to-`hclk` release).**
  - State: IDLE.
  - `hreadyout=1`, `hresp=00`, `hrdata=0`.
  - `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, `pstrb=0`.
  - Timeout counter: 0.
- **Reset mid-transfer.** Aborts immediately with no completion; all outputs go to their reset values.
- **Latency with zero-wait `pready`** (T0 = acceptance edge):
  - Read: SETUP in T1, ACCESS in T2, `hreadyout=1` with valid `hrdata` in T3.
  - Write: WDATA in T1, SETUP in T2, ACCESS in T3, `hreadyout=1` in T4.
- **APB wait states.** Each ACCESS cycle with `pready=0` adds one cycle. `hreadyout` stays 0 throughout.
- **Back-to-back transfers.** A new transfer is accepted in the completion (IDLE) cycle, so `psel` deasserts for at least one cycle between APB transfers.
- **ERROR response.** Always exactly two cycles: one with `hreadyout=0, hresp=01`, then one with `hreadyout=1, hresp=01`.
- **`hrdata` after errors and writes.** `hrdata` is not updated on an error or a write and holds its last value.

## Test plan
- **Write, zero wait.** Word write to `haddr=0x0000_2004` with `hwdata=0xDEAD_BEEF`, `pready=1`.
  - `psel=4'b0100`, `paddr=0x2004`, `pwdata=0xDEADBEEF`, `pstrb=4'hF`.
  - `hreadyout` low in T1–T3, high in T4, `hresp=00`.
- **Read, 3 wait states.** Read of slave 1 at `0x1008`, `prdata[63:32]=0x1234_5678`, `pready[1]` low for 3 ACCESS cycles.
  - ACCESS lasts 4 cycles.
  - `hrdata=0x12345678` in the completion cycle, T6.
- **Byte write.** `hsize=0`, `haddr=0x3003`, `hwdata=0xAB00_0000`.
  - `pstrb=4'b1000`, `psel=4'b1000`.
- **Slave error.** `pslverr[0]=1` together with `pready[0]=1`.
  - Two-cycle ERROR: `hresp=01` with `hreadyout` 0 then 1; next cycle `hresp=00`.
- **Decode and alignment errors.** With `NUM_SLAVES=3`, an access to `0x3000`, and separately a word access to `0x1002`.
  - ERR1 directly, `psel` stays 0 throughout.
- **Timeout and back-to-back.** With `TIMEOUT=4` and `pready` stuck at 0: exactly 4 ACCESS cycles, then ERROR; a second read accepted in ERR2 starts SETUP in the next cycle. Separately, assert `hresetn=0` during ACCESS: outputs go to reset values immediately.

Source files
------------

// File: rtl/ahb_apb4_bridge.sv
// ahb_apb4_bridge
//   Converts one AHB-Lite transfer at a time into an APB4 SETUP/ACCESS
//   sequence to one of NUM_SLAVES peripherals. Slave errors, decode errors
//   (bad slave index, oversized or misaligned access) and ACCESS timeouts
//   all produce the two-cycle AHB ERROR response.
//
// Ports
//   hclk, hresetn          : clock, asynchronous active-low reset
//   hsel .. hready_in      : AHB-Lite slave-side inputs
//   hrdata, hreadyout, hresp : AHB-Lite slave-side outputs
//   psel .. pstrb          : APB4 requester outputs (psel is one-hot)
//   prdata, pready, pslverr  : APB4 completer inputs, one slice/bit per slave
module ahb_apb4_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic                             hsel,
  input  logic [ADDR_WIDTH-1:0]            haddr,
  input  logic [1:0]                       htrans,
  input  logic                             hwrite,
  input  logic [2:0]                       hsize,
  input  logic [DATA_WIDTH-1:0]            hwdata,
  input  logic                             hready_in,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hreadyout,
  output logic [1:0]                       hresp,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW   = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t state_reg, state_next;

  logic                  accept, dec_err, size_bad, misalign, idx_bad;
  logic                  sel_ready, sel_err, timeout_hit;
  logic [SW-1:0]         idx_in, idx_reg;
  logic [OFFW-1:0]       off;
  logic [OFFW:0]         nbytes;
  logic [OFFW+1:0]       strb_end;
  logic [NB-1:0]         strb_in;
  logic [NUM_SLAVES-1:0] onehot;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [CW-1:0]         cnt_reg;
  logic [DATA_WIDTH-1:0] hrdata_reg, pwdata_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [NB-1:0]         pstrb_reg;
  logic                  pwrite_reg;
  logic                  unused_htrans0;

  // htrans[0] only separates NONSEQ/SEQ and IDLE/BUSY; both pairs behave alike here.
  assign unused_htrans0 = htrans[0];

  assign idx_in = haddr[SEL_LSB +: SW];
  assign off    = haddr[OFFW-1:0];
  // New transfers are only taken while hreadyout is high (IDLE or ERR2).
  assign accept = hsel & hready_in & htrans[1] &
                  ((state_reg == S_IDLE) | (state_reg == S_ERR2));

  always_comb begin
    size_bad = (hsize > 3'(OFFW));
    nbytes   = size_bad ? '0 : ((OFFW+1)'(1) << hsize);
    misalign = |((OFFW+1)'(off) & (nbytes - (OFFW+1)'(1)));
    idx_bad  = ({1'b0, idx_in} >= (SW+1)'(NUM_SLAVES));
    dec_err  = idx_bad | size_bad | misalign;
    strb_end = (OFFW+2)'(off) + (OFFW+2)'(nbytes);
  end

  genvar gi;
  // Byte lane gi is written when it lies in [off, off + bytes).
  generate
    for (gi = 0; gi < NB; gi++) begin : g_strb
      assign strb_in[gi] = ((OFFW+2)'(gi) >= (OFFW+2)'(off)) &&
                           ((OFFW+2)'(gi) < strb_end);
    end
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign onehot[gi] = (idx_reg == SW'(gi));
    end
  endgenerate

  // Only the addressed slave's handshake and data are observed.
  assign sel_ready = |(pready & onehot);
  assign sel_err   = |(pslverr & onehot);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (onehot[i]) sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Counter equals the number of completed wait cycles, so the last allowed
  // ACCESS cycle is the one where it reads TIMEOUT-1.
  assign timeout_hit = !sel_ready && (cnt_reg == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_ERR2: begin
        if (accept) state_next = dec_err ? S_ERR1 : (hwrite ? S_WDATA : S_SETUP);
        else        state_next = S_IDLE;
      end
      S_WDATA:  state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready)        state_next = sel_err ? S_ERR1 : S_IDLE;
        else if (timeout_hit) state_next = S_ERR1;
      end
      S_ERR1:   state_next = S_ERR2;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    hreadyout = 1'b0;
    hresp     = 2'b00;
    psel      = '0;
    penable   = 1'b0;
    case (state_reg)
      S_IDLE:   hreadyout = 1'b1;
      S_SETUP:  psel = onehot;
      S_ACCESS: begin
        psel    = onehot;
        penable = 1'b1;
      end
      S_ERR1:   hresp = 2'b01;
      S_ERR2: begin
        hreadyout = 1'b1;
        hresp     = 2'b01;
      end
      default: ;
    endcase
  end

  // Transfer attributes, write data, wait counter and read data
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      idx_reg    <= '0;
      pstrb_reg  <= '0;
      pwdata_reg <= '0;
      cnt_reg    <= '0;
      hrdata_reg <= '0;
    end else begin
      if (accept) begin
        paddr_reg  <= haddr;
        pwrite_reg <= hwrite;
        idx_reg    <= idx_in;
        pstrb_reg  <= hwrite ? strb_in : '0;
      end
      // hwdata belongs to the data phase, i.e. the cycle after acceptance.
      if (state_reg == S_WDATA) pwdata_reg <= hwdata;
      if (state_reg == S_SETUP)
        cnt_reg <= '0;
      else if ((state_reg == S_ACCESS) && !sel_ready)
        cnt_reg <= cnt_reg + CW'(1);
      if ((state_reg == S_ACCESS) && sel_ready && !sel_err && !pwrite_reg)
        hrdata_reg <= sel_rdata;
    end
  end

  assign hrdata = hrdata_reg;
  assign paddr  = paddr_reg;
  assign pwrite = pwrite_reg;
  assign pwdata = pwdata_reg;
  assign pstrb  = pstrb_reg;

endmodule

// File: tb/tb_ahb_apb4_bridge.sv
// Self-checking bench for ahb_apb4_bridge. Instance u_a: 4 slaves,
// TIMEOUT=4. Instance u_b: 3 slaves (decode-error cases), only selected via hsel_b.
module tb_ahb_apb4_bridge;

  localparam int TO = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;

  logic [31:0]  hrdata_a, paddr_a, pwdata_a;
  logic         hreadyout_a, penable_a, pwrite_a;
  logic [1:0]   hresp_a;
  logic [3:0]   psel_a, pstrb_a, pready_a, pslverr_a;
  logic [127:0] prdata_a;

  logic [31:0]  hrdata_b, paddr_b, pwdata_b;
  logic         hreadyout_b, penable_b, pwrite_b;
  logic [1:0]   hresp_b;
  logic [2:0]   psel_b, pready_b, pslverr_b;
  logic [3:0]   pstrb_b;
  logic [95:0]  prdata_b;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mdl_hrdata_a, mdl_hrdata_b;

  always #5 hclk = ~hclk;

  ahb_apb4_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT(TO)) u_a (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(hrdata_a), .hreadyout(hreadyout_a), .hresp(hresp_a), .psel(psel_a),
    .penable(penable_a), .pwrite(pwrite_a), .paddr(paddr_a), .pwdata(pwdata_a),
    .pstrb(pstrb_a), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

  ahb_apb4_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(12), .TIMEOUT(TO)) u_b (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(hrdata_b), .hreadyout(hreadyout_b), .hresp(hresp_b), .psel(psel_b),
    .penable(penable_b), .pwrite(pwrite_b), .paddr(paddr_b), .pwdata(pwdata_b),
    .pstrb(pstrb_b), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

  // One expected bus cycle, as seen on the AHB and APB side.
  typedef struct packed {
    logic       rdy;
    logic [1:0] resp;
    logic [3:0] psel;
    logic       pen;
    logic       pr;    // pready driven by the slave model in an ACCESS cycle
    logic       done;  // last cycle of the transfer
  } exp_t;

  function automatic exp_t mk(input logic rdy, input logic [1:0] resp, input logic [3:0] psel,
                              input logic pen, input logic pr, input logic done);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.psel = psel; e.pen = pen; e.pr = pr; e.done = done;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one AHB transfer starting in a cycle where hreadyout is high and
  // returns at the falling edge of its final (hreadyout-high) cycle.
  task automatic xfer(input bit on_b, input logic [31:0] addr, input bit wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits, input bit slverr);
    int   nsl, idx, n_acc, acc_i;
    bit   derr, err_end;
    exp_t q[$];
    exp_t e;
    logic [3:0]  sel, strb, o_psel, o_pstrb;
    logic [31:0] o_paddr, o_pwdata, o_hrdata;
    logic        o_rdy, o_pen, o_pwrite;
    logic [1:0]  o_resp;

    nsl  = on_b ? 3 : 4;
    idx  = int'((addr >> 12) & 32'd3);
    derr = (idx >= nsl) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    sel  = 4'(1 << idx);
    strb = 4'h0;
    if (wr && size <= 3'd2) strb = 4'((((1 << (1 << size)) - 1) << (addr % 4)));
    if (waits >= TO) begin n_acc = TO; err_end = 1'b1; end
    else begin n_acc = waits + 1; err_end = slverr; end

    if (derr) begin
      q.push_back(mk(1'b0, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b1, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1));
    end else begin
      if (wr) q.push_back(mk(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b0, 2'b00, sel, 1'b0, 1'b0, 1'b0));
      for (int j = 0; j < n_acc; j++)
        q.push_back(mk(1'b0, 2'b00, sel, 1'b1, (j >= waits), 1'b0));
      if (err_end) begin
        q.push_back(mk(1'b0, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1));
      end else begin
        q.push_back(mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1));
      end
    end

    // Address phase
    hsel_a = !on_b; hsel_b = on_b; haddr = addr; htrans = 2'b10;
    hwrite = wr; hsize = size; hready_in = 1'b1;
    if (!on_b) begin
      prdata_a[idx*32 +: 32] = rdata;
      pslverr_a[idx] = slverr;
    end

    acc_i = 0;
    foreach (q[k]) begin
      @(negedge hclk);
      e = q[k];
      o_rdy    = on_b ? hreadyout_b : hreadyout_a;
      o_resp   = on_b ? hresp_b     : hresp_a;
      o_psel   = on_b ? {1'b0, psel_b} : psel_a;
      o_pen    = on_b ? penable_b   : penable_a;
      o_paddr  = on_b ? paddr_b     : paddr_a;
      o_pwrite = on_b ? pwrite_b    : pwrite_a;
      o_pwdata = on_b ? pwdata_b    : pwdata_a;
      o_pstrb  = on_b ? pstrb_b     : pstrb_a;
      o_hrdata = on_b ? hrdata_b    : hrdata_a;
      chk("hreadyout", o_rdy, e.rdy);
      chk("hresp", o_resp, e.resp);
      chk("psel", o_psel, e.psel);
      chk("penable", o_pen, e.pen);
      if (e.psel != 4'h0) begin
        chk("paddr", o_paddr, addr);
        chk("pwrite", o_pwrite, wr);
        chk("pstrb", o_pstrb, strb);
        if (wr) chk("pwdata", o_pwdata, wdata);
      end
      if (e.done) begin
        if (!derr && !err_end && !wr) begin
          if (on_b) mdl_hrdata_b = rdata; else mdl_hrdata_a = rdata;
        end
        chk("hrdata", o_hrdata, on_b ? mdl_hrdata_b : mdl_hrdata_a);
      end
      // Inputs for the current cycle
      hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00;
      hwdata = (k == 0 && wr) ? wdata : $urandom;
      for (int i = 0; i < 4; i++) begin
        if (i != idx) begin
          pready_a[i]  = 1'($urandom);
          pslverr_a[i] = 1'($urandom);
        end
      end
      if (!on_b && idx < 4) pready_a[idx] = e.pen ? e.pr : 1'($urandom);
      if (e.pen) acc_i++;
    end
    $display("xfer %s %s addr=%08h size=%0d waits=%0d slverr=%0d derr=%0d access_cycles=%0d",
             on_b ? "b" : "a", wr ? "WR" : "RD", addr, size, waits, slverr, derr, acc_i);
  endtask

  // Cycles in which the bridge must not start a transfer.
  task automatic idle(input int variant);
    hsel_a = 1'b1; htrans = 2'b10; hready_in = 1'b1; haddr = 32'h0000_1000; hwrite = 1'b0; hsize = 3'd2;
    case (variant)
      0: htrans = 2'b00;
      1: htrans = 2'b01;
      2: hready_in = 1'b0;
      default: hsel_a = 1'b0;
    endcase
    @(negedge hclk);
    chk("idle_hreadyout", hreadyout_a, 1'b1);
    chk("idle_hresp", hresp_a, 2'b00);
    chk("idle_psel", psel_a, 4'h0);
    chk("idle_penable", penable_a, 1'b0);
    hsel_a = 1'b0; htrans = 2'b00; hready_in = 1'b1;
    $display("idle variant=%0d", variant);
  endtask

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    int          idx, offs;

    hresetn = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0; hready_in = 1'b1;
    prdata_a = '0; pready_a = '0; pslverr_a = '0;
    prdata_b = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    pready_b = 3'b111; pslverr_b = 3'b000;
    mdl_hrdata_a = '0; mdl_hrdata_b = '0;

    repeat (3) @(negedge hclk);
    chk("rst_hreadyout", hreadyout_a, 1'b1);
    chk("rst_hresp", hresp_a, 2'b00);
    chk("rst_hrdata", hrdata_a, 32'h0);
    chk("rst_psel", psel_a, 4'h0);
    chk("rst_penable", penable_a, 1'b0);
    chk("rst_pwrite", pwrite_a, 1'b0);
    chk("rst_paddr", paddr_a, 32'h0);
    chk("rst_pwdata", pwdata_a, 32'h0);
    chk("rst_pstrb", pstrb_a, 4'h0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Directed cases
    xfer(1'b0, 32'h0000_2004, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h0000_1008, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 3, 1'b0);
    xfer(1'b0, 32'h0000_3003, 1'b1, 3'd0, 32'hAB00_0000, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h0000_0010, 1'b0, 3'd2, 32'h0, 32'h5555_AAAA, 0, 1'b1);
    idle(0);
    xfer(1'b1, 32'h0000_3000, 1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h0000_1002, 1'b1, 3'd2, 32'h1111_2222, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h0000_2010, 1'b0, 3'd2, 32'h0, 32'hC0C0_0002, 0, 1'b0);
    xfer(1'b0, 32'h0000_1000, 1'b0, 3'd2, 32'h0, 32'h0BAD_0BAD, 10, 1'b0);
    xfer(1'b0, 32'h0000_2000, 1'b0, 3'd2, 32'h0, 32'h600D_F00D, 1, 1'b0);
    idle(1);
    idle(2);
    idle(3);

    // Randomized transfers, back-to-back or separated by ignored cycles
    for (int n = 0; n < 60; n++) begin
      idx  = $urandom_range(0, 3);
      size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      offs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3)
                                          : ($urandom_range(0, 3) & ~((1 << size) - 1));
      addr = ($urandom & 32'hFFFF_0000) | (32'(idx) << 12) | ($urandom & 32'h0000_0FF0) | 32'(offs);
      xfer(1'b0, addr, 1'($urandom), size, $urandom, $urandom,
           $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end

    // Reset in the middle of an ACCESS phase
    hsel_a = 1'b1; haddr = 32'h0000_1000; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; hready_in = 1'b1;
    pready_a = 4'h0; pslverr_a = 4'h0;
    @(negedge hclk);
    hsel_a = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("mid_penable_before", penable_a, 1'b1);
    hresetn = 1'b0;
    #1;
    mdl_hrdata_a = '0;
    chk("mid_psel", psel_a, 4'h0);
    chk("mid_penable", penable_a, 1'b0);
    chk("mid_hreadyout", hreadyout_a, 1'b1);
    chk("mid_hresp", hresp_a, 2'b00);
    chk("mid_hrdata", hrdata_a, 32'h0);
    chk("mid_paddr", paddr_a, 32'h0);
    chk("mid_pwrite", pwrite_a, 1'b0);
    chk("mid_pwdata", pwdata_a, 32'h0);
    chk("mid_pstrb", pstrb_a, 4'h0);
    $display("reset asserted during ACCESS");
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    xfer(1'b0, 32'h0000_3008, 1'b0, 3'd2, 32'h0, 32'h7777_8888, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
